pwm_duty_calc: RTL and testbench
================================

Name: pwm_duty_calc

Overview:
Downstream stage of the PWM detector. Consumes per-period high/low pulse counts and averages them over 2^AVG_LOG2 periods. It then computes duty cycle as high*DUTY_SCALE/period with a sequential restoring divider and publishes duty and average period to the MicroBlaze GPIO inputs. It replaces shift-based averaging with an exact, truncated ratio.

Parameters:
CNT_WIDTH, 32, width of incoming high/low counts
AVG_LOG2, 4, log2 of periods averaged per result (1..8)
DUTY_SCALE, 1000, full-scale duty value (per-mille); must be < 65536
MIN_PERIOD, 2, periods (high+low) below this are dropped as glitches

Ports:
pwd_clk  in  1  system clock
sysreset  in  1  synchronous, active-high reset
in_valid  in  1  one completed PWM period is presented
in_high_count  in  CNT_WIDTH  high-phase clock count for that period
in_low_count  in  CNT_WIDTH  low-phase clock count for that period
in_ready  out  1  block accepts a sample this cycle
avg_restart  in  1  discard the partial average window
duty_out  out  16  averaged duty, 0..DUTY_SCALE
period_avg_out  out  CNT_WIDTH+1  averaged period in clocks
out_valid  out  1  one-cycle strobe when a new result is published
drop_count  out  8  saturating count of dropped short periods

Behaviour:
- Reset applies on a pwd_clk edge with sysreset=1, as a synchronous, active-high reset. All outputs are 0 and all accumulators are 0. State is ACCUM. in_ready is 1 on the first cycle after reset.
- Accept occurs when in_valid && in_ready. in_ready = (state==ACCUM) && !avg_restart.
- Accepted sample: period = high+low, computed at CNT_WIDTH+1 bits with no overflow.
  - If period < MIN_PERIOD: the sample is dropped. drop_count increments and saturates at 255. Accumulators and sample_cnt are unchanged.
  - Otherwise: high_acc += high and per_acc += period. Both accumulators are CNT_WIDTH+1+AVG_LOG2 bits and cannot overflow. sample_cnt increments.
- When the accept makes sample_cnt == 2^AVG_LOG2, the next state is LOAD.
- States:
  - ACCUM: accepts samples as described above.
  - LOAD: 1 cycle. num = high_acc*DUTY_SCALE (constant multiply). den = per_acc. rem = num. q = 0. i = 15.
  - DIV: 16 cycles, one quotient bit per cycle from bit 15 down to bit 0. If rem >= (den<<i), then rem -= den<<i and q[i] = 1. This is exact because high_acc <= per_acc gives q <= DUTY_SCALE < 2^16. Truncation, no rounding.
  - PUBLISH: 1 cycle. duty_out <= q. period_avg_out <= per_acc >> AVG_LOG2 (truncated). out_valid = 1. Accumulators, sample_cnt and drop-independent state are cleared. Return to ACCUM.
- Latency: the final accept occurs at edge k. out_valid is high in the cycle following edge k+18, and in_ready is 1 in that same cycle.
- duty_out and period_avg_out hold their values between publishes.
- in_ready is 0 in LOAD, DIV and PUBLISH. An upstream sample presented then is not consumed; upstream holds or overwrites it.
- avg_restart in ACCUM clears high_acc, per_acc and sample_cnt. A simultaneous in_valid is not accepted (restart wins). avg_restart is ignored outside ACCUM. drop_count is cleared only by reset.
- sysreset mid-LOAD/DIV: the result is discarded, no out_valid is produced, and all values reset as above.
- Edge values: high=0 gives duty 0. low=0 with high >= MIN_PERIOD gives duty DUTY_SCALE.

Decomposition:
- Package pwm_pkg: state enum (ACCUM, LOAD, DIV, PUBLISH), DUTY_W=16, accumulator width function ACC_W(CNT_WIDTH, AVG_LOG2), default DUTY_SCALE.
- One sub-module: pwm_seq_divider, a 16-iteration restoring divider with start/done handshake, instantiated in the LOAD/DIV portion.

Test Plan:
- AVG_LOG2=2, four samples of high=250 and low=750 -> duty_out=250, period_avg_out=1000, out_valid exactly 18 cycles after the 4th accept, single cycle.
- Samples (100,900), (200,800), (300,700), (400,600) -> duty 250. Four samples of (1,2) -> duty 333 (truncated), period_avg_out=3.
- Four samples of (0,500) -> duty 0. Four samples of (500,0) -> duty 1000. Four samples of (2^32-1, 2^32-1) -> duty 500, period_avg_out=2^33-2.
- Sample (1,0) -> dropped, drop_count=1, next result still needs 4 valid samples. 300 glitch samples -> drop_count=255.
- in_valid held during DIV -> in_ready=0, no accept. avg_restart after 2 samples, then 4 samples of (10,30) -> duty 250 (earlier samples excluded). Restart and in_valid together -> sample not accepted.
- sysreset asserted on DIV cycle 5 -> next cycle all outputs 0, no out_valid, fresh window of 4 required.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the PWM duty-cycle calculator slice.
package pwm_pkg;

    localparam int DUTY_W             = 16;
    localparam int DEFAULT_DUTY_SCALE = 1000;

    typedef logic [1:0] state_t;

    localparam state_t ST_ACCUM   = 2'd0;
    localparam state_t ST_LOAD    = 2'd1;
    localparam state_t ST_DIV     = 2'd2;
    localparam state_t ST_PUBLISH = 2'd3;

    // Accumulators hold 2^avg_log2 periods of cnt_width+1 bits without overflow.
    function automatic int acc_w(input int cnt_width, input int avg_log2);
        return cnt_width + 1 + avg_log2;
    endfunction

endpackage

// File: rtl/pwm_seq_divider.sv
// Restoring divider, one quotient bit per cycle (MSB first), DUTY_W cycles after start.
// start must not be raised while busy; done marks the cycle of the final iteration.
module pwm_seq_divider
    import pwm_pkg::*;
#(
    parameter int NUM_W = 51,
    parameter int DEN_W = 35
) (
    input  logic              pwd_clk,
    input  logic              sysreset,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [DEN_W-1:0]  den,
    output logic              done,
    output logic [DUTY_W-1:0] q
);

    localparam int IDX_W = $clog2(DUTY_W);

    logic [NUM_W-1:0] rem;
    logic [DEN_W-1:0] den_r;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic [NUM_W-1:0] trial;

    // den<<15 never exceeds NUM_W because NUM_W = DEN_W + DUTY_W.
    assign trial = NUM_W'(den_r) << bit_idx;
    assign done  = busy && (bit_idx == '0);

    always_ff @(posedge pwd_clk) begin
        if (sysreset) begin
            rem     <= '0;
            den_r   <= '0;
            q       <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            rem     <= num;
            den_r   <= den;
            q       <= '0;
            bit_idx <= IDX_W'(DUTY_W - 1);
            busy    <= 1'b1;
        end else if (busy) begin
            if (rem >= trial) begin
                rem        <= rem - trial;
                q[bit_idx] <= 1'b1;
            end
            if (bit_idx == '0) begin
                busy <= 1'b0;
            end else begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_calc.sv
// Averages 2^AVG_LOG2 PWM periods and publishes truncated duty = high*DUTY_SCALE/period.
// Result strobes 18 cycles after the window's last accept; in_ready is low while computing.
module pwm_duty_calc
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int AVG_LOG2   = 4,
    parameter int DUTY_SCALE = DEFAULT_DUTY_SCALE,
    parameter int MIN_PERIOD = 2
) (
    input  logic                 pwd_clk,
    input  logic                 sysreset,
    input  logic                 in_valid,
    input  logic [CNT_WIDTH-1:0] in_high_count,
    input  logic [CNT_WIDTH-1:0] in_low_count,
    output logic                 in_ready,
    input  logic                 avg_restart,
    output logic [DUTY_W-1:0]    duty_out,
    output logic [CNT_WIDTH:0]   period_avg_out,
    output logic                 out_valid,
    output logic [7:0]           drop_count
);

    localparam int PER_W  = CNT_WIDTH + 1;
    localparam int ACC_W  = acc_w(CNT_WIDTH, AVG_LOG2);
    localparam int NUM_W  = ACC_W + DUTY_W;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);

    state_t            state;
    logic [ACC_W-1:0]  high_acc;
    logic [ACC_W-1:0]  per_acc;
    logic [SCNT_W-1:0] sample_cnt;
    logic [PER_W-1:0]  period;
    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [NUM_W-1:0]  div_num;
    logic [DUTY_W-1:0] div_q;

    assign period    = PER_W'(in_high_count) + PER_W'(in_low_count);
    assign in_ready  = (state == ST_ACCUM) && !avg_restart;
    assign accept    = in_valid && in_ready;
    assign div_start = (state == ST_LOAD);
    assign div_num   = NUM_W'(high_acc) * NUM_W'(DUTY_SCALE);

    pwm_seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (ACC_W)
    ) u_div (
        .pwd_clk  (pwd_clk),
        .sysreset (sysreset),
        .start    (div_start),
        .num      (div_num),
        .den      (per_acc),
        .done     (div_done),
        .q        (div_q)
    );

    always_ff @(posedge pwd_clk) begin
        if (sysreset) begin
            state          <= ST_ACCUM;
            high_acc       <= '0;
            per_acc        <= '0;
            sample_cnt     <= '0;
            duty_out       <= '0;
            period_avg_out <= '0;
            out_valid      <= 1'b0;
            drop_count     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (avg_restart) begin
                        high_acc   <= '0;
                        per_acc    <= '0;
                        sample_cnt <= '0;
                    end else if (accept) begin
                        if (period < PER_W'(MIN_PERIOD)) begin
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                        end else begin
                            high_acc   <= high_acc + ACC_W'(in_high_count);
                            per_acc    <= per_acc + ACC_W'(period);
                            sample_cnt <= sample_cnt + 1'b1;
                            if (sample_cnt == LAST_SAMPLE) begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_PUBLISH;
                    end
                end
                default: begin
                    duty_out       <= div_q;
                    period_avg_out <= per_acc[ACC_W-1:AVG_LOG2];
                    out_valid      <= 1'b1;
                    high_acc       <= '0;
                    per_acc        <= '0;
                    sample_cnt     <= '0;
                    state          <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Randomized and directed bench for pwm_duty_calc against a window-level reference model.
module tb_pwm_duty_calc;

    localparam int CW = 32;
    localparam int AL = 2;
    localparam int DS = 1000;
    localparam int MP = 2;

    logic          pwd_clk = 1'b0;
    logic          sysreset = 1'b1;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_high_count = '0;
    logic [CW-1:0] in_low_count = '0;
    logic          in_ready;
    logic          avg_restart = 1'b0;
    logic [15:0]   duty_out;
    logic [CW:0]   period_avg_out;
    logic          out_valid;
    logic [7:0]    drop_count;

    pwm_duty_calc #(
        .CNT_WIDTH  (CW),
        .AVG_LOG2   (AL),
        .DUTY_SCALE (DS),
        .MIN_PERIOD (MP)
    ) dut (
        .pwd_clk        (pwd_clk),
        .sysreset       (sysreset),
        .in_valid       (in_valid),
        .in_high_count  (in_high_count),
        .in_low_count   (in_low_count),
        .in_ready       (in_ready),
        .avg_restart    (avg_restart),
        .duty_out       (duty_out),
        .period_avg_out (period_avg_out),
        .out_valid      (out_valid),
        .drop_count     (drop_count)
    );

    always #5 pwd_clk = ~pwd_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a window is a list of accepted non-glitch periods; once it holds
    // 2^AL of them the result is fixed and appears on the bus 18 edges later.
    longint unsigned cyc = 0;
    longint unsigned m_pub_cyc = 0;
    longint unsigned m_last_acc_cyc = 0;
    bit              m_live = 0;
    bit              m_busy = 0;
    bit              m_ov = 0;
    bit              m_acc_evt = 0;
    logic [63:0]     m_hs = 0, m_ps = 0, m_per = 0;
    logic [63:0]     m_duty = 0, m_pavg = 0, m_pub_duty = 0, m_pub_pavg = 0;
    int              m_n = 0;
    int              m_drop = 0;

    always @(posedge pwd_clk) begin
        cyc++;
        m_acc_evt = 0;
        if (sysreset) begin
            m_live = 1; m_busy = 0; m_ov = 0;
            m_hs = 0; m_ps = 0; m_n = 0; m_drop = 0;
            m_duty = 0; m_pavg = 0;
        end else begin
            m_ov = 0;
            if (m_busy) begin
                if (cyc == m_pub_cyc) begin
                    m_ov = 1; m_duty = m_pub_duty; m_pavg = m_pub_pavg; m_busy = 0;
                end
            end else if (avg_restart) begin
                m_hs = 0; m_ps = 0; m_n = 0;
            end else if (in_valid) begin
                m_acc_evt = 1;
                m_last_acc_cyc = cyc;
                m_per = 64'(in_high_count) + 64'(in_low_count);
                if (m_per < 64'(MP)) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_hs += 64'(in_high_count);
                    m_ps += m_per;
                    m_n++;
                    if (m_n == (1 << AL)) begin
                        m_busy = 1;
                        m_pub_cyc = cyc + 18;
                        m_pub_duty = (m_hs * DS) / m_ps;
                        m_pub_pavg = m_ps >> AL;
                        m_hs = 0; m_ps = 0; m_n = 0;
                    end
                end
            end
        end
    end

    always @(negedge pwd_clk) begin
        if (m_live) begin
            check("out_valid", 64'(out_valid), 64'(m_ov));
            check("in_ready", 64'(in_ready), 64'(!m_busy && !avg_restart));
            check("duty_out", 64'(duty_out), m_duty);
            check("period_avg_out", 64'(period_avg_out), m_pavg);
            check("drop_count", 64'(drop_count), 64'(m_drop));
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [CW-1:0] h, input logic [CW-1:0] l);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_high_count = h;
        in_low_count = l;
        do begin
            @(posedge pwd_clk); #1;
            budget++;
        end while (!m_acc_evt && budget < 100);
        if (!m_acc_evt) begin
            tests++; fails++;
            $display("FAIL send: sample (%0d,%0d) not accepted within 100 cycles", h, l);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pwd_clk); #1; end
    endtask

    task automatic wait_pub(input string name, input logic [63:0] exp_duty, input logic [63:0] exp_pavg);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge pwd_clk);
            if (out_valid === 1'b1) break;
            n++;
        end
        if (n >= 60) begin
            tests++; fails++;
            $display("FAIL %s: no out_valid within 60 cycles", name);
        end else begin
            check({name, "_duty"}, 64'(duty_out), exp_duty);
            check({name, "_pavg"}, 64'(period_avg_out), exp_pavg);
            check({name, "_latency"}, cyc - m_last_acc_cyc, 64'd18);
            check({name, "_model"}, m_duty, exp_duty);
        end
        @(posedge pwd_clk); #1;
    endtask

    task automatic run_same(input string name, input logic [CW-1:0] h, input logic [CW-1:0] l,
                            input logic [63:0] exp_duty, input logic [63:0] exp_pavg);
        for (int i = 0; i < 4; i++) send(h, l);
        wait_pub(name, exp_duty, exp_pavg);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [CW-1:0] h, l;

        repeat (3) @(posedge pwd_clk);
        #1;
        check("rst_duty", 64'(duty_out), 64'd0);
        check("rst_pavg", 64'(period_avg_out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        sysreset = 1'b0;
        idle(2);

        run_same("quarter", 32'd250, 32'd750, 64'd250, 64'd1000);

        send(32'd100, 32'd900); send(32'd200, 32'd800);
        send(32'd300, 32'd700); send(32'd400, 32'd600);
        wait_pub("mixed", 64'd250, 64'd1000);

        run_same("third", 32'd1, 32'd2, 64'd333, 64'd3);
        run_same("zero_high", 32'd0, 32'd500, 64'd0, 64'd500);
        run_same("zero_low", 32'd500, 32'd0, 64'd1000, 64'd500);
        run_same("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd500, 64'h1_FFFF_FFFE);

        // A glitch inside a window must not count toward the four samples.
        for (int i = 0; i < 3; i++) send(32'd10, 32'd30);
        send(32'd1, 32'd0);
        check("drop_one", 64'(drop_count), 64'd1);
        idle(25);
        send(32'd10, 32'd30);
        wait_pub("after_drop", 64'd250, 64'd40);

        // Sample held through the computation must stay unconsumed.
        for (int i = 0; i < 4; i++) send(32'd900, 32'd100);
        in_valid = 1'b1; in_high_count = 32'd999; in_low_count = 32'd1;
        idle(10);
        check("held_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_pub("held", 64'd900, 64'd1000);
        run_same("post_held", 32'd10, 32'd30, 64'd250, 64'd40);

        // Restart discards partial window and wins over a simultaneous sample.
        send(32'd900, 32'd100); send(32'd900, 32'd100);
        avg_restart = 1'b1; in_valid = 1'b1; in_high_count = 32'd900; in_low_count = 32'd100;
        idle(1);
        avg_restart = 1'b0; in_valid = 1'b0;
        run_same("restart", 32'd10, 32'd30, 64'd250, 64'd40);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                avg_restart = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                in_high_count = 32'd50; in_low_count = 32'd50;
                idle(1);
                avg_restart = 1'b0; in_valid = 1'b0;
            end else if (r < 3) begin
                h = 32'($urandom_range(0, 1));
                l = (h == 0) ? 32'($urandom_range(0, 1)) : 32'd0;
                send(h, l);
            end else if (r < 5) begin
                idle($urandom_range(1, 4));
            end else if (r < 7) begin
                send($urandom(), $urandom());
            end else begin
                send(32'($urandom_range(0, 5000)), 32'($urandom_range(0, 5000)));
            end
        end
        idle(30);

        for (int i = 0; i < 300; i++) send(32'(i % 2), 32'd0);
        check("drop_sat", 64'(drop_count), 64'd255);

        // Reset during the sixth cycle of the divide must discard the window.
        for (int i = 0; i < 4; i++) send(32'd300, 32'd700);
        idle(5);
        sysreset = 1'b1;
        idle(1);
        sysreset = 1'b0;
        check("mid_rst_duty", 64'(duty_out), 64'd0);
        check("mid_rst_pavg", 64'(period_avg_out), 64'd0);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 3; i++) send(32'd10, 32'd30);
        idle(30);
        send(32'd10, 32'd30);
        wait_pub("after_rst", 64'd250, 64'd40);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
